// File: rtl/risc_pkg.sv
// risc_pkg: shared encodings for the RISC-Y sequencer slice.
//   phase_t  - phase generator code (FETCH..UPDATE), advances +1 mod 4
//   opcode_t - 3-bit instruction opcode (HLT..JMP)
//   loads_ac - true for opcodes that read memory into the accumulator
//   next_phase - legal successor of a phase (UPDATE wraps to FETCH)
package risc_pkg;

  typedef enum logic [1:0] {
    PH_FETCH   = 2'd0,
    PH_DECODE  = 2'd1,
    PH_EXECUTE = 2'd2,
    PH_UPDATE  = 2'd3
  } phase_t;

  typedef enum logic [2:0] {
    OP_HLT = 3'd0,
    OP_SKZ = 3'd1,
    OP_ADD = 3'd2,
    OP_AND = 3'd3,
    OP_XOR = 3'd4,
    OP_LDA = 3'd5,
    OP_STO = 3'd6,
    OP_JMP = 3'd7
  } opcode_t;

  // ALU ops plus LDA: these read an operand and load the accumulator.
  function automatic logic loads_ac(input opcode_t op);
    return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
  endfunction

  function automatic phase_t next_phase(input phase_t p);
    return phase_t'(p + 2'd1);
  endfunction

endpackage

// File: rtl/phase_tracker.sv
// phase_tracker: remembers the previously sampled phase, flags a phase entry
// (sampled phase differs from the stored one) and checks that the change is
// the legal +1 mod 4 step. An illegal change latches a sticky sequence error.
//   CLK, RST   - clock / asynchronous active-low reset
//   i_stop     - machine halted: freeze tracking, suppress entry
//   i_phase    - phase code sampled this cycle
//   o_entry    - this cycle is a phase entry (combinational)
//   o_illegal  - this entry is not the legal successor (combinational)
//   o_seq_err  - sticky registered sequence error
import risc_pkg::*;

module phase_tracker (
  input  logic   CLK,
  input  logic   RST,
  input  logic   i_stop,
  input  phase_t i_phase,
  output logic   o_entry,
  output logic   o_illegal,
  output logic   o_seq_err
);

  phase_t r_prev;
  logic   r_seq_err;
  logic   w_stop;
  logic   w_entry;
  logic   w_illegal;

  assign w_stop    = i_stop | r_seq_err;
  assign w_entry   = !w_stop && (i_phase != r_prev);
  assign w_illegal = w_entry && (i_phase != next_phase(r_prev));

  // Reset to UPDATE so the first FETCH after reset counts as an entry.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_prev    <= PH_UPDATE;
      r_seq_err <= 1'b0;
    end else if (!w_stop) begin
      r_prev <= i_phase;
      if (w_illegal)
        r_seq_err <= 1'b1;
    end
  end

  assign o_entry   = w_entry;
  assign o_illegal = w_illegal;
  assign o_seq_err = r_seq_err;

endmodule

// File: rtl/seq_controller.sv
// seq_controller: instruction sequence controller for the RISC-Y CPU.
// Decodes phase/opcode/zero into registered datapath control and gates the
// phase generator, freezing the machine on HLT or a phase-sequence error.
//   CLK, RST        - clock / asynchronous active-low reset
//   PHASE, OPCODE   - phase code and instruction opcode
//   ZERO            - accumulator equals zero
//   PH_EN_N         - phase generator enable, active-low
//   SEL, RD, DATA_E - levels held for the whole phase
//   LD_IR, INC_PC, LD_AC, WR, LD_PC - one-clock strobes on phase entry
//   HALT, SEQ_ERR   - sticky halt / sequence error, cleared only by reset
import risc_pkg::*;

module seq_controller (
  input  logic       CLK,
  input  logic       RST,
  input  logic [1:0] PHASE,
  input  logic [2:0] OPCODE,
  input  logic       ZERO,
  output logic       PH_EN_N,
  output logic       SEL,
  output logic       RD,
  output logic       DATA_E,
  output logic       LD_IR,
  output logic       INC_PC,
  output logic       LD_AC,
  output logic       WR,
  output logic       LD_PC,
  output logic       HALT,
  output logic       SEQ_ERR
);

  phase_t  w_phase;
  opcode_t w_op;
  logic    w_entry;
  logic    w_illegal;
  logic    w_seq_err;

  logic r_ph_en_n, r_sel, r_rd, r_data_e;
  logic r_ld_ir, r_inc_pc, r_ld_ac, r_wr, r_ld_pc;
  logic r_halt, r_skip;

  logic w_ph_en_n, w_sel, w_rd, w_data_e;
  logic w_ld_ir, w_inc_pc, w_ld_ac, w_wr, w_ld_pc;
  logic w_halt, w_skip;

  assign w_phase = phase_t'(PHASE);
  assign w_op    = opcode_t'(OPCODE);

  // A sequence error always sets HALT too, so HALT alone stops tracking.
  phase_tracker u_tracker (
    .CLK       (CLK),
    .RST       (RST),
    .i_stop    (r_halt),
    .i_phase   (w_phase),
    .o_entry   (w_entry),
    .o_illegal (w_illegal),
    .o_seq_err (w_seq_err)
  );

  always_comb begin
    w_ph_en_n = 1'b1;
    w_sel     = 1'b0;
    w_rd      = 1'b0;
    w_data_e  = 1'b0;
    w_ld_ir   = 1'b0;
    w_inc_pc  = 1'b0;
    w_ld_ac   = 1'b0;
    w_wr      = 1'b0;
    w_ld_pc   = 1'b0;
    w_halt    = r_halt;
    w_skip    = r_skip;
    if (!r_halt) begin
      if (w_illegal) begin
        w_halt = 1'b1;
      end else begin
        w_ph_en_n = 1'b0;
        unique case (w_phase)
          PH_FETCH: begin
            w_sel   = 1'b1;
            w_rd    = 1'b1;
            w_ld_ir = w_entry;
            if (w_entry)
              w_skip = 1'b0;
          end
          PH_DECODE: begin
            w_rd = loads_ac(w_op);
          end
          PH_EXECUTE: begin
            w_rd     = loads_ac(w_op);
            w_data_e = (w_op == OP_STO);
            if (w_entry) begin
              w_inc_pc = (w_op != OP_HLT);
              w_ld_ac  = loads_ac(w_op);
              w_wr     = (w_op == OP_STO);
              if (w_op == OP_SKZ)
                w_skip = ZERO;
              if (w_op == OP_HLT) begin
                w_halt    = 1'b1;
                w_ph_en_n = 1'b1;
              end
            end
          end
          PH_UPDATE: begin
            w_data_e = (w_op == OP_STO);
            if (w_entry) begin
              w_ld_pc  = (w_op == OP_JMP);
              w_inc_pc = (w_op == OP_SKZ) && r_skip;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_ph_en_n <= 1'b1;
      r_sel     <= 1'b0;
      r_rd      <= 1'b0;
      r_data_e  <= 1'b0;
      r_ld_ir   <= 1'b0;
      r_inc_pc  <= 1'b0;
      r_ld_ac   <= 1'b0;
      r_wr      <= 1'b0;
      r_ld_pc   <= 1'b0;
      r_halt    <= 1'b0;
      r_skip    <= 1'b0;
    end else begin
      r_ph_en_n <= w_ph_en_n;
      r_sel     <= w_sel;
      r_rd      <= w_rd;
      r_data_e  <= w_data_e;
      r_ld_ir   <= w_ld_ir;
      r_inc_pc  <= w_inc_pc;
      r_ld_ac   <= w_ld_ac;
      r_wr      <= w_wr;
      r_ld_pc   <= w_ld_pc;
      r_halt    <= w_halt;
      r_skip    <= w_skip;
    end
  end

  assign PH_EN_N = r_ph_en_n;
  assign SEL     = r_sel;
  assign RD      = r_rd;
  assign DATA_E  = r_data_e;
  assign LD_IR   = r_ld_ir;
  assign INC_PC  = r_inc_pc;
  assign LD_AC   = r_ld_ac;
  assign WR      = r_wr;
  assign LD_PC   = r_ld_pc;
  assign HALT    = r_halt;
  assign SEQ_ERR = w_seq_err;

endmodule

// File: tb/tb_seq_controller.sv
// tb_seq_controller: directed and randomized bench for seq_controller with a
// rule-level reference model and per-cycle comparison of all outputs.
module tb_seq_controller;

  localparam int F = 0, D = 1, E = 2, U = 3;
  localparam int O_HLT = 0, O_SKZ = 1, O_ADD = 2, O_AND = 3,
                 O_XOR = 4, O_LDA = 5, O_STO = 6, O_JMP = 7;

  // Output vector bit masks: {PH_EN_N,SEL,RD,DATA_E,LD_IR,INC_PC,LD_AC,WR,LD_PC,HALT,SEQ_ERR}
  localparam logic [10:0] M_PHEN = 11'h400, M_SEL  = 11'h200, M_RD   = 11'h100,
                          M_DE   = 11'h080, M_LDIR = 11'h040, M_INC  = 11'h020,
                          M_LDAC = 11'h010, M_WR   = 11'h008, M_LDPC = 11'h004,
                          M_HALT = 11'h002, M_ERR  = 11'h001;
  localparam logic [10:0] M_STRB = 11'h07C;
  localparam logic [10:0] M_ALL  = 11'h7FF;
  localparam logic [10:0] V_RST  = 11'h400;

  logic       CLK = 1'b0;
  logic       RST;
  logic [1:0] PHASE;
  logic [2:0] OPCODE;
  logic       ZERO;
  logic       PH_EN_N, SEL, RD, DATA_E, LD_IR, INC_PC, LD_AC, WR, LD_PC, HALT, SEQ_ERR;

  seq_controller dut (
    .CLK     (CLK),
    .RST     (RST),
    .PHASE   (PHASE),
    .OPCODE  (OPCODE),
    .ZERO    (ZERO),
    .PH_EN_N (PH_EN_N),
    .SEL     (SEL),
    .RD      (RD),
    .DATA_E  (DATA_E),
    .LD_IR   (LD_IR),
    .INC_PC  (INC_PC),
    .LD_AC   (LD_AC),
    .WR      (WR),
    .LD_PC   (LD_PC),
    .HALT    (HALT),
    .SEQ_ERR (SEQ_ERR)
  );

  always #5 CLK = ~CLK;

  logic [10:0] dut_vec;
  assign dut_vec = {PH_EN_N, SEL, RD, DATA_E, LD_IR, INC_PC, LD_AC, WR, LD_PC, HALT, SEQ_ERR};

  int          n_checks = 0;
  int          n_errors = 0;
  logic        chk_en = 1'b0;
  logic [10:0] exp_vec;
  logic [10:0] lit_mask = '0;
  logic [10:0] lit_val = '0;
  string       lit_name = "";

  // Reference model state
  int m_prev;
  bit m_skip, m_halt, m_err;

  task automatic model_reset();
    m_prev  = U;
    m_skip  = 1'b0;
    m_halt  = 1'b0;
    m_err   = 1'b0;
    exp_vec = V_RST;
  endtask

  // Expected outputs after the next rising edge, given the sampled inputs.
  task automatic model_step(input int ph, input int op, input int z);
    bit ent, legal, is_ld;
    bit sel, rd, de, ldir, inc, ldac, wr, ldpc;
    if (m_halt || m_err) begin
      exp_vec = {1'b1, 8'b0, m_halt, m_err};
      return;
    end
    ent   = (ph != m_prev);
    legal = !ent || (ph == (m_prev + 1) % 4);
    if (!legal) begin
      m_halt  = 1'b1;
      m_err   = 1'b1;
      exp_vec = {1'b1, 8'b0, 1'b1, 1'b1};
      return;
    end
    is_ld = (op == O_ADD) || (op == O_AND) || (op == O_XOR) || (op == O_LDA);
    sel  = (ph == F);
    rd   = (ph == F) || (((ph == D) || (ph == E)) && is_ld);
    de   = ((ph == E) || (ph == U)) && (op == O_STO);
    ldir = 0; inc = 0; ldac = 0; wr = 0; ldpc = 0;
    if (ent) begin
      if (ph == F) begin
        ldir   = 1;
        m_skip = 0;
      end
      if (ph == E) begin
        inc  = (op != O_HLT);
        ldac = is_ld;
        wr   = (op == O_STO);
        if (op == O_SKZ) m_skip = (z != 0);
        if (op == O_HLT) m_halt = 1'b1;
      end
      if (ph == U) begin
        ldpc = (op == O_JMP);
        inc  = (op == O_SKZ) && m_skip;
      end
    end
    m_prev  = ph;
    exp_vec = {m_halt, sel, rd, de, ldir, inc, ldac, wr, ldpc, m_halt, 1'b0};
  endtask

  // Single compare process: full model comparison every cycle, plus an
  // optional hand-computed literal expectation on selected bits.
  always @(negedge CLK) begin
    if (chk_en) begin
      n_checks++;
      if (dut_vec !== exp_vec) begin
        n_errors++;
        $display("FAIL model_cmp t=%0t got=%b expected=%b", $time, dut_vec, exp_vec);
      end
      if (lit_mask != '0) begin
        n_checks++;
        if ((dut_vec & lit_mask) !== lit_val) begin
          n_errors++;
          $display("FAIL %s t=%0t got=%b expected=%b mask=%b",
                   lit_name, $time, dut_vec & lit_mask, lit_val, lit_mask);
        end
      end
    end
  end

  // Called at negedge+1; drives one cycle and returns at the next negedge+1.
  task automatic cyc(input int ph, input int op, input int z,
                     input logic [10:0] mask = '0, input logic [10:0] val = '0,
                     input string name = "");
    PHASE  = 2'(ph);
    OPCODE = 3'(op);
    ZERO   = (z != 0);
    model_step(ph, op, z);
    lit_mask = mask;
    lit_val  = val;
    lit_name = name;
    @(negedge CLK);
    #1;
    lit_mask = '0;
  endtask

  // Reset asserted between edges: the next negedge sees reset values with no
  // intervening clock edge, so the clear must be asynchronous.
  task automatic rst_pulse();
    model_step(int'(PHASE), int'(OPCODE), int'(ZERO));
    @(posedge CLK);
    #2;
    RST   = 1'b0;
    PHASE = 2'(U);
    model_reset();
    lit_mask = M_ALL;
    lit_val  = V_RST;
    lit_name = "async_reset";
    @(negedge CLK);
    #1;
    lit_mask = '0;
    @(negedge CLK);
    #1;
    RST = 1'b1;
  endtask

  initial begin
    int cur, opc, r, halt_cyc;
    RST    = 1'b0;
    PHASE  = 2'(U);
    OPCODE = 3'(O_LDA);
    ZERO   = 1'b0;
    model_reset();
    lit_mask = M_ALL;
    lit_val  = V_RST;
    lit_name = "reset_values";
    chk_en   = 1'b1;
    @(negedge CLK);
    #1;
    lit_mask = '0;
    RST = 1'b1;
    cyc(U, O_LDA, 0, M_PHEN, 11'h000, "ph_en_release");

    // LDA, one clock per phase
    cyc(F, O_LDA, 0, M_STRB | M_SEL | M_RD, M_LDIR | M_SEL | M_RD, "lda_fetch");
    cyc(D, O_LDA, 0, M_STRB | M_SEL | M_RD, M_RD, "lda_decode");
    cyc(E, O_LDA, 0, M_STRB | M_RD | M_DE, M_INC | M_LDAC | M_RD, "lda_execute");
    cyc(U, O_LDA, 0, M_STRB | M_RD, 11'h000, "lda_update");

    // SKZ taken (ZERO=1) then not taken
    cyc(F, O_SKZ, 0);
    cyc(D, O_SKZ, 0, M_RD, 11'h000, "skz_decode_rd");
    cyc(E, O_SKZ, 1, M_STRB, M_INC, "skz1_execute");
    cyc(U, O_SKZ, 0, M_STRB, M_INC, "skz1_update");
    cyc(F, O_SKZ, 1);
    cyc(D, O_SKZ, 1);
    cyc(E, O_SKZ, 0, M_STRB, M_INC, "skz0_execute");
    cyc(U, O_SKZ, 1, M_STRB, 11'h000, "skz0_update");

    // STO with EXECUTE held three clocks
    cyc(F, O_STO, 0);
    cyc(D, O_STO, 0, M_DE | M_RD, 11'h000, "sto_decode");
    cyc(E, O_STO, 0, M_DE | M_STRB, M_DE | M_WR | M_INC, "sto_exec1");
    cyc(E, O_STO, 0, M_DE | M_STRB, M_DE, "sto_exec2");
    cyc(E, O_STO, 0, M_DE | M_STRB, M_DE, "sto_exec3");
    cyc(U, O_STO, 0, M_DE | M_STRB, M_DE, "sto_update");

    // JMP, then mid-phase opcode change without strobe re-fire
    cyc(F, O_JMP, 0);
    cyc(D, O_JMP, 0);
    cyc(E, O_JMP, 0, M_STRB, M_INC, "jmp_execute");
    cyc(U, O_JMP, 0, M_STRB, M_LDPC, "jmp_update");
    cyc(F, O_ADD, 0);
    cyc(D, O_ADD, 0);
    cyc(E, O_ADD, 0, M_STRB | M_RD, M_INC | M_LDAC | M_RD, "add_execute");
    cyc(E, O_STO, 0, M_STRB | M_RD | M_DE, M_DE, "midphase_op_change");

    // Reset while the WR strobe is being issued
    cyc(U, O_STO, 0);
    cyc(F, O_STO, 0);
    cyc(D, O_STO, 0);
    cyc(E, O_STO, 0, M_WR, M_WR, "sto_wr_before_reset");
    rst_pulse();

    // HLT freezes the machine
    cyc(F, O_HLT, 0, M_LDIR, M_LDIR, "hlt_fetch");
    cyc(D, O_HLT, 0);
    cyc(E, O_HLT, 0, M_ALL, M_PHEN | M_HALT, "hlt_execute");
    cyc(U, O_JMP, 0, M_ALL, M_PHEN | M_HALT, "hlt_frozen_u");
    cyc(F, O_LDA, 0, M_ALL, M_PHEN | M_HALT, "hlt_frozen_f");
    cyc(D, O_LDA, 0);
    cyc(E, O_LDA, 0, M_ALL, M_PHEN | M_HALT, "hlt_frozen_e");
    rst_pulse();

    // Illegal jump FETCH -> EXECUTE
    cyc(F, O_LDA, 0);
    cyc(E, O_LDA, 0, M_ALL, M_PHEN | M_HALT | M_ERR, "jump_0_2");
    cyc(U, O_LDA, 0, M_ALL, M_PHEN | M_HALT | M_ERR, "err_sticky");
    rst_pulse();

    // Illegal jump combined with HLT
    cyc(F, O_HLT, 0);
    cyc(E, O_HLT, 0, M_ALL, M_PHEN | M_HALT | M_ERR, "illegal_with_hlt");
    rst_pulse();

    // Backward step DECODE -> FETCH
    cyc(F, O_ADD, 0);
    cyc(D, O_ADD, 0);
    cyc(F, O_ADD, 0, M_ALL, M_PHEN | M_HALT | M_ERR, "backward_1_0");
    rst_pulse();

    // Randomized phase/opcode activity
    cur      = U;
    opc      = O_LDA;
    halt_cyc = 0;
    for (int i = 0; i < 3000; i++) begin
      if (m_halt || m_err) begin
        halt_cyc++;
        if (halt_cyc > 3) begin
          rst_pulse();
          cur      = U;
          halt_cyc = 0;
          continue;
        end
      end
      r = int'($urandom_range(0, 99));
      if (r < 50) begin
        cur = (cur + 1) % 4;
        if (cur == F)
          opc = ($urandom_range(0, 99) < 4) ? O_HLT : int'($urandom_range(1, 7));
      end else if (r >= 98) begin
        cur = (cur + 2 + int'($urandom_range(0, 1))) % 4;
      end
      if ($urandom_range(0, 19) == 0)
        opc = int'($urandom_range(1, 7));
      cyc(cur, opc, int'($urandom_range(0, 1)));
    end

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
